// File: rtl/keypad_encoder.sv
// 5x5 passive-matrix keypad scanner with debounce and one-shot key encoding.
// Produces keycode/newkey/key_down for the calculator core; code = row*5 + col.
module keypad_encoder #(
  parameter int SETTLE       = 4,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] row_n,
  output logic [4:0] col_n,
  output logic [4:0] keycode,
  output logic       newkey,
  output logic       key_down
);

  localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
  localparam int DW = $clog2(SETTLE) + 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYC - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE - 1);

  typedef enum logic [2:0] {
    SCAN     = 3'd0,
    DEBOUNCE = 3'd1,
    EMIT     = 3'd2,
    HOLD     = 3'd3
  } state_t;

  // {valid, row index}; valid only when exactly one row is pulled low
  function automatic logic [3:0] decode_row(input logic [4:0] r);
    logic [3:0] res;
    case (r)
      5'b11110: res = {1'b1, 3'd0};
      5'b11101: res = {1'b1, 3'd1};
      5'b11011: res = {1'b1, 3'd2};
      5'b10111: res = {1'b1, 3'd3};
      5'b01111: res = {1'b1, 3'd4};
      default:  res = {1'b0, 3'd0};
    endcase
    return res;
  endfunction

  function automatic logic [2:0] next_col(input logic [2:0] c);
    return (c == 3'd4) ? 3'd0 : c + 3'd1;
  endfunction

  logic [1:0]    rst_sync_q, rst_sync_d;
  logic          rst_core_n;
  logic [4:0]    row_meta_q, row_meta_d;
  logic [4:0]    row_s_q, row_s_d;
  state_t        state_q, state_d;
  logic [2:0]    col_idx_q, col_idx_d;
  logic [4:0]    col_n_q, col_n_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    pat_q, pat_d;
  logic [4:0]    code_q, code_d;
  logic [4:0]    keycode_q, keycode_d;
  logic          newkey_q, newkey_d;
  logic          key_down_q, key_down_d;
  logic [3:0]    row_hit_s;

  assign rst_core_n = rst_sync_q[1];
  assign col_n      = col_n_q;
  assign keycode    = keycode_q;
  assign newkey     = newkey_q;
  assign key_down   = key_down_q;

  // Reset release is synchronised; assertion still clears everything at once
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset synchroniser flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  // Scan / debounce / emit / hold sequencing
  always_comb begin
    row_meta_d = row_n;
    row_s_d    = row_meta_q;
    row_hit_s  = decode_row(row_s_q);
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    dwell_d    = dwell_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    code_d     = code_q;
    keycode_d  = keycode_q;
    newkey_d   = 1'b0;
    key_down_d = key_down_q;
    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          if (row_hit_s[3]) begin
            pat_d   = row_s_q;
            code_d  = {2'b00, row_hit_s[2:0]} * 5'd5 + {2'b00, col_idx_q};
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            // Idle or ghosted column: move on without reporting anything
            col_idx_d = next_col(col_idx_q);
            dwell_d   = '0;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (row_s_q == pat_q) begin
          if (cnt_q == CNT_LAST) begin
            state_d = EMIT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d   = SCAN;
          col_idx_d = next_col(col_idx_q);
          dwell_d   = '0;
        end
      end
      EMIT: begin
        newkey_d   = 1'b1;
        keycode_d  = code_q;
        key_down_d = 1'b1;
        cnt_d      = '0;
        state_d    = HOLD;
      end
      HOLD: begin
        // Any low row in the held column, including a second key, restarts release timing
        if (row_s_q == 5'b11111) begin
          if (cnt_q == CNT_LAST) begin
            key_down_d = 1'b0;
            col_idx_d  = 3'd0;
            dwell_d    = '0;
            cnt_d      = '0;
            state_d    = SCAN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d    = SCAN;
        col_idx_d  = 3'd0;
        dwell_d    = '0;
        cnt_d      = '0;
        key_down_d = 1'b0;
      end
    endcase
    col_n_d = ~(5'b00001 << col_idx_d);
  end

  // Core state and registered outputs
  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      row_meta_q <= 5'b11111;
      row_s_q    <= 5'b11111;
      state_q    <= SCAN;
      col_idx_q  <= 3'd0;
      col_n_q    <= 5'b11110;
      dwell_q    <= '0;
      cnt_q      <= '0;
      pat_q      <= 5'b11111;
      code_q     <= 5'h00;
      keycode_q  <= 5'h00;
      newkey_q   <= 1'b0;
      key_down_q <= 1'b0;
    end else begin
      row_meta_q <= row_meta_d;
      row_s_q    <= row_s_d;
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      col_n_q    <= col_n_d;
      dwell_q    <= dwell_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      code_q     <= code_d;
      keycode_q  <= keycode_d;
      newkey_q   <= newkey_d;
      key_down_q <= key_down_d;
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder: a passive keypad model drives row_n from col_n,
// and a per-cycle compare process checks outputs against expected press events.
module tb_keypad_encoder;

  localparam int DC  = 16;
  localparam int SET = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  row_n;
  logic [4:0]  col_n;
  logic [4:0]  keycode;
  logic        newkey;
  logic        key_down;
  logic [24:0] keys;

  int          n_chk = 0;
  int          n_fail = 0;
  int          exp_q[$];
  logic [4:0]  m_code = 5'h00;
  logic        m_kd = 1'b0;
  int          m_col = 0;
  int          rel_run = 0;
  int          stable_run = 0;
  logic [24:0] prev_keys = 25'd0;
  logic        prev_newkey = 1'b0;
  int          n_newkey = 0;

  always #5 clk = ~clk;

  keypad_encoder #(.SETTLE(SET), .DEBOUNCE_CYC(DC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_n    (row_n),
    .col_n    (col_n),
    .keycode  (keycode),
    .newkey   (newkey),
    .key_down (key_down)
  );

  // Passive matrix: a pressed key connects its row to its column
  always_comb begin
    row_n = 5'b11111;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (keys[r*5+c] && (col_n[c] == 1'b0)) row_n[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the event-level model
  always @(negedge clk) begin : compare
    logic held;
    stable_run = (keys == prev_keys) ? stable_run + 1 : 1;
    prev_keys  = keys;
    if (!rst_n) begin
      chk("rst_col_n", int'(col_n), 5'b11110);
      chk("rst_newkey", int'(newkey), 0);
      chk("rst_key_down", int'(key_down), 0);
      chk("rst_keycode", int'(keycode), 0);
      m_code  = 5'h00;
      m_kd    = 1'b0;
      rel_run = 0;
    end else begin
      chk("col_onehot", $countones(~col_n), 1);
      if (newkey) begin
        n_newkey++;
        chk("newkey_adjacent", int'(prev_newkey), 0);
        if (exp_q.size() == 0) begin
          chk("newkey_unexpected", exp_q.size(), 1);
        end else begin
          m_code = 5'(exp_q.pop_front());
        end
        chk("newkey_key_pressed", int'((keycode < 5'd25) ? keys[keycode] : 1'b0), 1);
        chk("newkey_stable_press", int'(stable_run >= DC + 2), 1);
        m_kd    = 1'b1;
        m_col   = int'(m_code) % 5;
        rel_run = 0;
      end
      chk("keycode", int'(keycode), int'(m_code));
      if (m_kd) begin
        held = 1'b0;
        for (int r = 0; r < 5; r++) if (keys[r*5+m_col]) held = 1'b1;
        rel_run = held ? 0 : rel_run + 1;
        if (!key_down) begin
          chk("release_delay_min", int'(rel_run >= DC), 1);
          chk("release_delay_max", int'(rel_run <= DC + 3), 1);
          m_kd = 1'b0;
        end else if (rel_run > DC + 3) begin
          chk("key_down_stuck", int'(key_down), 0);
          m_kd = 1'b0;
        end
      end else begin
        chk("key_down_idle", int'(key_down), 0);
      end
    end
    prev_newkey = newkey;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits for col_n to newly switch to target (returns just after that edge)
  task automatic wait_col(input logic [4:0] target, input int budget, input string name);
    logic found;
    logic [4:0] prev;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      prev = col_n;
      @(posedge clk);
      #1;
      if (col_n == target && prev != target) found = 1'b1;
    end
    chk(name, int'(found), 1);
  endtask

  task automatic wait_newkey(input int budget, input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (newkey) found = 1'b1;
    end
    chk(name, int'(found), 1);
  endtask

  logic [4:0] seq [6] = '{5'h15, 5'h18, 5'h0A, 5'h14, 5'h03, 5'h04};

  initial begin : stim
    int base;
    logic [4:0] seen;
    rst_n = 1'b0;
    keys  = 25'd0;
    tick(3);
    chk("init_col_n", int'(col_n), 5'b11110);
    chk("init_keycode", int'(keycode), 0);
    rst_n = 1'b1;
    tick(10);

    // Row 4 / column 0 held 200 clocks: one pulse, code 0x14
    base = n_newkey;
    exp_q.push_back(5'h14);
    keys[20] = 1'b1;
    wait_newkey(100, "t2_newkey");
    chk("t2_code", int'(keycode), 5'h14);
    chk("t2_key_down", int'(key_down), 1);
    tick(150);
    chk("t2_no_repeat", n_newkey - base, 1);
    keys = 25'd0;
    tick(DC - 4);
    chk("t2_kd_still_high", int'(key_down), 1);
    tick(8);
    chk("t2_kd_released", int'(key_down), 0);
    tick(20);

    // Bouncing r4c3 then stable: exactly one pulse, code 0x17
    base = n_newkey;
    exp_q.push_back(5'h17);
    for (int i = 0; i < 6; i++) begin
      keys[23] = 1'b1;
      tick(5);
      keys[23] = 1'b0;
      tick(5);
    end
    chk("t3_no_bounce_key", n_newkey - base, 0);
    keys[23] = 1'b1;
    wait_newkey(100, "t3_newkey");
    chk("t3_code", int'(keycode), 5'h17);
    tick(50);
    keys = 25'd0;
    tick(40);
    chk("t3_count", n_newkey - base, 1);

    // Short glitch on row 1 / column 2: rejected, scan continues at column 3
    base = n_newkey;
    wait_col(5'b11011, 60, "t4_reach_col2");
    keys[7] = 1'b1;
    tick(DC - 2);
    keys[7] = 1'b0;
    for (int i = 0; i < 40 && col_n == 5'b11011; i++) tick(1);
    chk("t4_resume_col", int'(col_n), 5'b10111);
    tick(50);
    chk("t4_no_newkey", n_newkey - base, 0);

    // Ghost pair in column 1: ignored until row 3 releases, then code 0x01
    base = n_newkey;
    seen = 5'b00000;
    keys[1]  = 1'b1;
    keys[16] = 1'b1;
    for (int i = 0; i < 150; i++) begin
      tick(1);
      seen = seen | ~col_n;
    end
    chk("t5_no_newkey", n_newkey - base, 0);
    chk("t5_scan_all_cols", int'(seen), 5'b11111);
    exp_q.push_back(5'h01);
    keys[16] = 1'b0;
    wait_newkey(100, "t5_newkey");
    chk("t5_code", int'(keycode), 5'h01);
    tick(5);
    keys = 25'd0;
    tick(40);

    // Reset in the middle of debounce
    base = n_newkey;
    wait_col(5'b11011, 60, "t1a_reach_col2");
    keys[12] = 1'b1;
    tick(10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1a_col_n", int'(col_n), 5'b11110);
    chk("t1a_newkey", int'(newkey), 0);
    chk("t1a_key_down", int'(key_down), 0);
    chk("t1a_keycode", int'(keycode), 0);
    keys = 25'd0;
    tick(3);
    rst_n = 1'b1;
    tick(60);
    chk("t1a_no_newkey", n_newkey - base, 0);

    // Reset in the middle of hold on r2c3 (code 0x0D)
    exp_q.push_back(5'h0D);
    keys[13] = 1'b1;
    wait_newkey(100, "t1b_newkey");
    chk("t1b_code", int'(keycode), 5'h0D);
    tick(20);
    chk("t1b_key_down_held", int'(key_down), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1b_col_n", int'(col_n), 5'b11110);
    chk("t1b_newkey", int'(newkey), 0);
    chk("t1b_key_down", int'(key_down), 0);
    chk("t1b_keycode", int'(keycode), 0);
    keys = 25'd0;
    tick(3);
    rst_n = 1'b1;
    tick(40);

    // Calculator key sequence, 100 clk presses with 100 clk gaps
    base = n_newkey;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(int'(seq[i]));
      keys[seq[i]] = 1'b1;
      tick(100);
      keys = 25'd0;
      tick(100);
    end
    chk("t6_count", n_newkey - base, 6);
    chk("t6_last_code", int'(keycode), 5'h04);
    chk("exp_queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
